reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one NBITS-wide holding register, the same structure as the team's simple q <= d register, between NREQS requesters.
- Requesters use val/rdy handshakes and are served round-robin.
- Each accepted write updates the register and produces a response carrying the writer's id and the written value.
- The response is held until the consumer accepts it. One write per cycle is sustained when the consumer is always ready.

Parameters:
NREQS, 4, number of requesters (>= 2, not required to be a power of two)
NBITS, 32, data width of the shared register
IDW, $clog2(NREQS), width of the requester id

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req_val  input  NREQS  request valid, bit i = requester i
req_rdy  output  NREQS  grant / ready, one-hot or zero
req_msg  input  NREQS*NBITS  write data; requester i at [i*NBITS +: NBITS]
q  output  NBITS  current shared register value
resp_val  output  1  response valid
resp_rdy  input  1  response consumer ready
resp_id  output  IDW  id of the requester whose write produced the response
resp_data  output  NBITS  value written, equal to q while resp_val=1

Behaviour:
- State:
  - FSM with two states: IDLE (no response pending) and RESP (response pending).
  - Priority pointer ptr, IDW bits.
  - Register q.
  - Response registers resp_id and resp_data.
- Reset (synchronous, reset=1 at posedge):
  - state=IDLE, ptr=0, q=0, resp_id=0, resp_data=0.
  - Outputs during and after the reset cycle: resp_val=0, req_rdy=0.
  - Reset takes priority over every other event, including an in-flight handshake in the same cycle. A pending response is dropped.
- Accept condition: can_acc = (state==IDLE) || (state==RESP && resp_rdy).
- Grant (combinational):
  - If can_acc, grant the first i with req_val[i]=1, scanning ptr, ptr+1, …, NREQS-1, 0, …, ptr-1 (wrap modulo NREQS; non-power-of-two NREQS wraps at NREQS, not 2^IDW).
  - req_rdy = one-hot of the granted index, otherwise all zero.
  - req_rdy depends combinationally on req_val and resp_rdy; requesters must not make req_val depend on req_rdy.
  - req_rdy is never asserted for a requester with req_val=0.
- Transfer on the posedge where req_val[g] && req_rdy[g]:
  - q <= req_msg[g], resp_data <= req_msg[g], resp_id <= g.
  - ptr <= (g+1) mod NREQS.
  - state <= RESP.
- Latency: write data visible on q and on the response one cycle after the request handshake.
- resp_val = (state==RESP).
  - resp_id and resp_data are stable while resp_val=1 && resp_rdy=0.
  - Response handshake completes on the posedge with resp_val && resp_rdy.
- FSM transitions:
  - IDLE: grant present -> RESP; otherwise stay IDLE.
  - RESP, resp_rdy=0: stay RESP; no grants; q is held.
  - RESP, resp_rdy=1, grant present: stay RESP with the new response loaded in the same cycle (back-to-back, full throughput).
  - RESP, resp_rdy=1, no grant: -> IDLE.
- ptr changes only on a transfer; it is unchanged when there are no requests or the response is stalled.
- q changes only on a transfer or reset. It holds indefinitely otherwise.
- All req_val=0: no state change except RESP -> IDLE on a response handshake.

Test Plan:
1. Reset with q pre-loaded, then all req_val=0 for 3 cycles -> q=0, resp_val=0, req_rdy=0000 every cycle.
2. Single write: req_val=0100, req_msg[2]=0xDEADBEEF, resp_rdy=1 -> req_rdy=0100 that cycle; next cycle q=0xDEADBEEF, resp_val=1, resp_id=2, resp_data=0xDEADBEEF; ptr=3.
3. Fairness: all four requesters hold req_val=1111 for 8 cycles with msg = 0x10+i, resp_rdy=1 -> grants in order 0,1,2,3,0,1,2,3; q sequence 0x10, 0x11, 0x12, 0x13, …, one write per cycle.
4. Back-pressure: after a grant to id 1, resp_rdy=0 for 3 cycles with req_val=1111 -> req_rdy=0000, resp_id=1 and q held for 3 cycles; on resp_rdy=1, req_rdy=0100 (id 2) in the same cycle.
5. Wrap with a gap: ptr=3, req_val=0011 -> id 0 granted, ptr=1; then req_val=0011 -> id 1 granted.
6. Reset mid-operation: state RESP, resp_rdy=1, req_val=1000 and reset=1 in the same cycle -> no transfer; next cycle q=0, resp_val=0, ptr=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbitrated shared write register with held response
module reg_write_arbiter #(
    parameter int NREQS = 4,
    parameter int NBITS = 32,
    parameter int IDW   = $clog2(NREQS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQS-1:0]       req_val,
    output logic [NREQS-1:0]       req_rdy,
    input  logic [NREQS*NBITS-1:0] req_msg,
    output logic [NBITS-1:0]       q,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [IDW-1:0]         resp_id,
    output logic [NBITS-1:0]       resp_data
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic             can_acc;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand_idx;
    int               cand;
    logic             xfer;
    logic [NBITS-1:0] gnt_msg;

    // A new write may only be taken when the response slot is free or is
    // being drained this very cycle; reset blocks every handshake.
    assign can_acc = !reset && ((state == IDLE) || resp_rdy);

    // Round-robin scan starting at ptr; the wrap is done at NREQS so that
    // non-power-of-two requester counts never visit an unused id.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQS) begin
                cand = cand - NREQS;
            end
            cand_idx = IDW'(cand);
            if (!gnt_found && req_val[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign xfer = can_acc && gnt_found;

    // One-hot ready for the granted requester only.
    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NREQS; i++) begin
            req_rdy[i] = xfer && (gnt_idx == IDW'(i));
        end
    end

    // Select the granted requester's write data.
    always_comb begin
        gnt_msg = '0;
        for (int i = 0; i < NREQS; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_msg = req_msg[i*NBITS +: NBITS];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NREQS.
    assign ptr_next = (gnt_idx == IDW'(NREQS - 1)) ? '0 : gnt_idx + 1'b1;

    // Response is visible only while a write is pending and not under reset.
    assign resp_val = (state == RESP) && !reset;

    // Next-state logic: a transfer always leaves a pending response; a drained
    // response with no replacement returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (xfer) begin
                    state_next = RESP;
                end else if (resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shared register, response payload and priority pointer update only on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            resp_data <= '0;
            resp_id   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            q         <= gnt_msg;
            resp_data <= gnt_msg;
            resp_id   <= gnt_idx;
            ptr       <= ptr_next;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - randomized self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int NREQS = 4;
    localparam int NBITS = 32;
    localparam int IDW   = 2;

    logic                   clk;
    logic                   reset;
    logic [NREQS-1:0]       req_val;
    logic [NREQS-1:0]       req_rdy;
    logic [NREQS*NBITS-1:0] req_msg;
    logic [NBITS-1:0]       q;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [IDW-1:0]         resp_id;
    logic [NBITS-1:0]       resp_data;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: pending flag, pointer, register and response payload
    logic              m_pend;
    int                m_ptr;
    logic [NBITS-1:0]  m_q;
    int                m_id;
    logic [NBITS-1:0]  m_data;
    logic [NREQS-1:0]  obs_rdy;

    reg_write_arbiter #(.NREQS(NREQS), .NBITS(NBITS), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_msg   (req_msg),
        .q         (q),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_id   (resp_id),
        .resp_data (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [NREQS-1:0] val, input logic rr,
                        input logic [NREQS*NBITS-1:0] msg);
        int eg;
        logic [NREQS*NBITS-1:0] sh;
        reset    = rst;
        req_val  = val;
        resp_rdy = rr;
        req_msg  = msg;
        @(negedge clk);
        eg = -1;
        if (!rst && (!m_pend || rr)) begin
            for (int k = 0; k < NREQS; k++) begin
                int j;
                j = (m_ptr + k) % NREQS;
                if (eg < 0 && (((val >> j) & 4'b0001) != 4'b0000)) eg = j;
            end
        end
        obs_rdy = req_rdy;
        check("req_rdy", 64'(req_rdy), (eg >= 0) ? (64'd1 << eg) : 64'd0);
        check("resp_val", 64'(resp_val), 64'(m_pend && !rst));
        check("q", 64'(q), 64'(m_q));
        if (m_pend && !rst) begin
            check("resp_id", 64'(resp_id), 64'(m_id));
            check("resp_data", 64'(resp_data), 64'(m_data));
        end
        if (rst) begin
            m_pend = 1'b0;
            m_ptr  = 0;
            m_q    = '0;
            m_id   = 0;
            m_data = '0;
        end else if (eg >= 0) begin
            sh     = msg >> (eg * NBITS);
            m_q    = sh[NBITS-1:0];
            m_data = sh[NBITS-1:0];
            m_id   = eg;
            m_ptr  = (eg + 1) % NREQS;
            m_pend = 1'b1;
        end else if (m_pend && rr) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQS*NBITS-1:0] msg;
        reset    = 1'b1;
        req_val  = '0;
        resp_rdy = 1'b1;
        req_msg  = '0;
        m_pend   = 1'b0;
        m_ptr    = 0;
        m_q      = '0;
        m_id     = 0;
        m_data   = '0;
        obs_rdy  = '0;
        @(posedge clk);
        #1;

        // reset with q pre-loaded, then idle cycles
        step(1'b0, 4'b0001, 1'b1, {96'd0, 32'hAAAA5555});
        check("preload_q", 64'(q), 64'h0000_0000_AAAA_5555);
        step(1'b1, 4'b0000, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 1'b1, '0);
        end
        check("rst_q", 64'(q), 64'd0);

        // single write from requester 2
        msg = '0;
        msg[2*NBITS +: NBITS] = 32'hDEADBEEF;
        step(1'b0, 4'b0100, 1'b1, msg);
        check("t2_rdy", 64'(obs_rdy), 64'h4);
        check("t2_q", 64'(q), 64'h0000_0000_DEAD_BEEF);
        check("t2_id", 64'(resp_id), 64'd2);
        step(1'b0, 4'b0000, 1'b1, '0);

        // fairness from ptr=0
        step(1'b1, 4'b0000, 1'b1, '0);
        msg = {32'h13, 32'h12, 32'h11, 32'h10};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 1'b1, msg);
            check("t3_rdy", 64'(obs_rdy), 64'd1 << (i % 4));
            check("t3_q", 64'(q), 64'h10 + 64'(i % 4));
        end

        // back-pressure after a grant to id 1
        step(1'b0, 4'b0010, 1'b1, msg);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 1'b0, msg);
            check("t4_stall_rdy", 64'(obs_rdy), 64'd0);
            check("t4_stall_q", 64'(q), 64'h11);
        end
        step(1'b0, 4'b1111, 1'b1, msg);
        check("t4_release_rdy", 64'(obs_rdy), 64'h4);

        // wrap with a gap from ptr=3
        step(1'b0, 4'b0011, 1'b1, msg);
        check("t5_wrap0", 64'(obs_rdy), 64'h1);
        step(1'b0, 4'b0011, 1'b1, msg);
        check("t5_wrap1", 64'(obs_rdy), 64'h2);

        // reset while a handshake would otherwise happen
        step(1'b1, 4'b1000, 1'b1, msg);
        check("t6_rst_rdy", 64'(obs_rdy), 64'd0);
        step(1'b0, 4'b0000, 1'b1, msg);
        check("t6_q", 64'(q), 64'd0);
        step(1'b0, 4'b1111, 1'b1, msg);
        check("t6_ptr0", 64'(obs_rdy), 64'h1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            msg = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), msg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
